mult_arbiter: RTL and testbench

Round-robin controller that shares one signed multiplier (the DPI-backed `multiplier` datapath or an RTL equivalent) among `NUM_REQ` requesters. It accepts one operand pair at a time through a per-requester valid/ready handshake and drives the multiplier's operand inputs. After a fixed `MUL_LAT` it captures the product and returns it on a single tagged response channel. It sits between the client blocks and the multiplier instance, and owns all sequencing of the multiplier.

---
 rtl/mult_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one signed multiplier among NUM_REQ requesters.
// Latency: accept edge to rsp_valid is MUL_LAT+2 cycles; at most one product in flight.
// Backpressure: rsp_ready low holds the response and keeps every req_ready low (no queueing).
module mult_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 32,
    parameter int  MUL_LAT = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    input  logic [DATA_W-1:0]         mul_result,
    output logic                      busy
);

    // Counter must hold MUL_LAT; a combinational multiplier still needs one bit.
    localparam int               CNT_W    = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
    // Pointer starts at the top index so requester 0 has first priority.
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    id_q;
    logic [DATA_W-1:0]  op_a_q;
    logic [DATA_W-1:0]  op_b_q;
    logic [DATA_W-1:0]  result_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;
    logic               cnt_zero;
    logic               in_idle;

    assign in_idle  = (state_q == ST_IDLE);
    assign cnt_zero = (cnt_q == '0);

    // Round-robin pick: first valid requester after the last one served, wrapping.
    always_comb begin : rr_pick
        int cand;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A transfer only happens in IDLE and never while reset is asserted.
    assign accept = in_idle && rst_n && grant_any;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept -> wait out the multiplier -> hold response until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_WAIT;
            ST_WAIT: if (cnt_zero)  state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grant is gated by reset so nothing looks accepted while it is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (rst_n) begin
                    req_ready = grant_oh;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Latency counter, fairness pointer and response tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            last_grant_q <= LAST_RST;
            id_q         <= '0;
        end else if (accept) begin
            cnt_q        <= CNT_LOAD;
            last_grant_q <= grant_idx;
            id_q         <= grant_idx;
        end else if (state_q == ST_WAIT && !cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Operand registers feed the multiplier directly and only change on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (accept) begin
            op_a_q <= req_a[grant_idx*DATA_W +: DATA_W];
            op_b_q <= req_b[grant_idx*DATA_W +: DATA_W];
        end
    end

    // Capture the product on the last WAIT cycle; it is passed through untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state_q == ST_WAIT && cnt_zero) begin
            result_q <= mul_result;
        end
    end

    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;

    // Grant is at most one-hot and silent during reset.
    a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    a_grant_rst:    assert property (@(posedge clk) !rst_n |-> (req_ready == '0));

    // A stalled response does not change under the consumer.
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_result)));

    // The multiplier sees stable operands for the whole wait.
    a_op_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_WAIT && !cnt_zero) |=> ($stable(mul_a) && $stable(mul_b)));

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized + directed bench for mult_arbiter with a scoreboard model.
// Latency: multiplier stand-in registers its product (MUL_LAT = 1).
// Backpressure: rsp_ready is driven low for directed and random stretches.
module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 1;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic [DATA_W-1:0]         mul_a;
    logic [DATA_W-1:0]         mul_b;
    logic [DATA_W-1:0]         mul_result;
    logic                      busy;

    always #5 clk = ~clk;

    mult_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .busy       (busy)
    );

    // Signed product, low DATA_W bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    // One-cycle multiplier stand-in: a too-early capture sees the previous product.
    always @(posedge clk) mul_result <= ref_mul(mul_a, mul_b);

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } txn_t;

    txn_t               exp_q[$];
    int                 tests = 0;
    int                 fails = 0;
    int                 to_cnt = 0;
    int                 rst_edges = 0;
    bit                 m_busy = 1'b0;
    int                 m_age = 0;
    int                 m_last = NUM_REQ - 1;
    logic [31:0]        m_mul_a = '0;
    logic [31:0]        m_mul_b = '0;
    logic [NUM_REQ-1:0] acc_mask = '0;
    bit                 reload = 1'b0;
    bit                 end_req = 1'b0;
    bit                 end_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_edges <= rst_n ? 0 : rst_edges + 1;

    // Monitor + reference model, evaluated on the falling edge.
    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0] exp_grant;
        int                 gid;
        int                 c;
        bit                 exp_rv;
        txn_t               t;
        if (!rst_n) begin
            check("rst_req_ready", 64'(req_ready), 64'(0));
            if (rst_edges > 0) begin
                check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_rsp_id", 64'(rsp_id), 64'(0));
                check("rst_rsp_result", 64'(rsp_result), 64'(0));
                check("rst_mul_a", 64'(mul_a), 64'(0));
                check("rst_mul_b", 64'(mul_b), 64'(0));
            end
            exp_q.delete();
            m_busy   = 1'b0;
            m_age    = 0;
            m_last   = NUM_REQ - 1;
            m_mul_a  = '0;
            m_mul_b  = '0;
            acc_mask = '0;
        end else begin
            acc_mask = '0;
            if (m_busy) m_age++;
            exp_rv = m_busy && (m_age >= MUL_LAT + 2);
            check("busy", 64'(busy), 64'(m_busy));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("mul_a", 64'(mul_a), 64'(m_mul_a));
            check("mul_b", 64'(mul_b), 64'(m_mul_b));
            if (m_busy) begin
                check("req_ready_busy", 64'(req_ready), 64'(0));
                if (exp_rv) begin
                    if (exp_q.size() == 0) begin
                        check("queue_nonempty", 64'(0), 64'(1));
                    end else begin
                        t = exp_q[0];
                        check("rsp_id", 64'(rsp_id), 64'(t.id));
                        check("rsp_result", 64'(rsp_result), 64'(t.p));
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            m_busy = 1'b0;
                        end
                    end
                end
            end else begin
                exp_grant = '0;
                gid = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (gid < 0 && req_valid[c]) gid = c;
                end
                if (gid >= 0) exp_grant[gid] = 1'b1;
                check("grant", 64'(req_ready), 64'(exp_grant));
                if (gid >= 0) begin
                    t.id = gid;
                    t.a  = req_a[gid*DATA_W +: DATA_W];
                    t.b  = req_b[gid*DATA_W +: DATA_W];
                    t.p  = ref_mul(t.a, t.b);
                    exp_q.push_back(t);
                    m_last   = gid;
                    m_busy   = 1'b1;
                    m_age    = 0;
                    m_mul_a  = t.a;
                    m_mul_b  = t.b;
                    acc_mask = exp_grant;
                end
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            check("wait_timeouts", 64'(to_cnt), 64'(0));
            check("drain_busy", 64'(busy), 64'(0));
            check("drain_queue", 64'(exp_q.size()), 64'(0));
        end
    end

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]               = 1'b1;
        req_a[i*DATA_W +: DATA_W]  = a;
        req_b[i*DATA_W +: DATA_W]  = b;
    endtask

    // Advance one cycle; accepted requesters either retire or reload a fresh pair.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_mask[i]) begin
                if (reload) set_req(i, rand_op(), rand_op());
                else        req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((req_valid != '0 || m_busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) to_cnt++;
    endtask

    initial begin
        // Reset held three cycles with everyone requesting; requester 0 must win first.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op());
        repeat (3) tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wait_idle();

        // Single op: 7 * -6 from requester 2.
        set_req(2, 32'd7, -32'sd6);
        wait_idle();

        // Round-robin with everyone continuously valid.
        reload = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op());
        repeat (24) tick();
        reload = 1'b0;
        wait_idle();

        // Backpressure: response held five cycles, released on the sixth.
        rsp_ready = 1'b0;
        set_req(1, $urandom, $urandom);
        tick();
        set_req(3, $urandom, $urandom);
        repeat (7) tick();
        rsp_ready = 1'b1;
        wait_idle();

        // Wrap/overflow cases.
        set_req(0, 32'h0001_0000, 32'h0001_0000);
        wait_idle();
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0002);
        wait_idle();

        // Abort: reset during WAIT of requester 1 with 2 and 3 pending.
        set_req(0, $urandom, $urandom);
        wait_idle();
        set_req(1, $urandom, $urandom);
        set_req(2, $urandom, $urandom);
        set_req(3, $urandom, $urandom);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle();

        // Random traffic with random backpressure and occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_op(), rand_op());
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        // Drain and close.
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        end_req = 1'b1;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
